usb_tx_encoder: RTL and testbench

- Serialises bytes from the USB transmit packet layer onto the full-speed D+/D- pair.
- Per byte: LSB-first shifting, NRZI encoding and bit stuffing.
- Per packet: appends the End-Of-Packet sequence.
- Sits between the TX packet controller and the bus pads. Mirrors the receive-side NRZI decoder and bit-unstuffer.

---
 rtl/usb_tx_encoder.sv | 211 +++++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_encoder
// Purpose  : Full-speed USB transmit serialiser. It shifts bytes LSB first,
//            applies NRZI encoding and bit stuffing, and appends the EOP.
//            When USB_TX_SYNC_EN is defined, an internal SYNC byte is sent first.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int                 c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_EOP  = 2'd2;

    logic [1:0]         r_state,    w_state_nxt;
    logic [7:0]         r_buf_data, w_buf_data_nxt;
    logic               r_buf_last, w_buf_last_nxt;
    logic               r_buf_full, w_buf_full_nxt;
    logic [7:0]         r_shift,    w_shift_nxt;
    logic               r_cur_last, w_cur_last_nxt;
    logic [3:0]         r_nbits,    w_nbits_nxt;
    logic [c_CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic               r_line,     w_line_nxt;
    logic               r_se0,      w_se0_nxt;
    logic [2:0]         r_ones,     w_ones_nxt;
    logic [1:0]         r_eop,      w_eop_nxt;
    logic               r_start,    w_start_nxt;
    logic               r_active,   w_active_nxt;
    logic               r_done,     w_done_nxt;
    logic               r_err,      w_err_nxt;
    logic               r_ready;

    logic       w_tick;
    logic       w_accept;
    logic [7:0] w_src;

    assign w_tick   = (r_cnt == c_LAST_CNT);
    assign w_accept = tx_valid & r_ready;
    // Once all 8 bits are out, the next data bit comes straight from the buffer.
    assign w_src    = (r_nbits == 4'd8) ? r_buf_data : r_shift;

    always_comb begin
        w_state_nxt    = r_state;
        w_buf_data_nxt = r_buf_data;
        w_buf_last_nxt = r_buf_last;
        w_buf_full_nxt = r_buf_full;
        w_shift_nxt    = r_shift;
        w_cur_last_nxt = r_cur_last;
        w_nbits_nxt    = r_nbits;
        w_cnt_nxt      = r_cnt;
        w_line_nxt     = r_line;
        w_se0_nxt      = r_se0;
        w_ones_nxt     = r_ones;
        w_eop_nxt      = r_eop;
        w_start_nxt    = r_start;
        w_active_nxt   = r_active;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;

        if (w_accept) begin
            w_buf_data_nxt = tx_data;
            w_buf_last_nxt = tx_last;
            w_buf_full_nxt = 1'b1;
        end

        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt  = '0;
                w_ones_nxt = 3'd0;
                if (r_buf_full) begin
                    w_state_nxt = c_ST_SEND;
                    w_start_nxt = 1'b1;
                    w_nbits_nxt = 4'd0;
`ifdef USB_TX_SYNC_EN
                    w_shift_nxt    = 8'h80;
                    w_cur_last_nxt = 1'b0;
`else
                    w_shift_nxt    = r_buf_data;
                    w_cur_last_nxt = r_buf_last;
                    w_buf_full_nxt = 1'b0;
`endif
                end
            end

            c_ST_SEND: begin
                if (r_start || w_tick) begin
                    w_cnt_nxt    = '0;
                    w_start_nxt  = 1'b0;
                    w_active_nxt = 1'b1;
                    if (r_ones == 3'd6) begin
                        w_line_nxt = ~r_line;
                        w_ones_nxt = 3'd0;
                    end else if ((r_nbits == 4'd8) && !r_buf_full) begin
                        w_state_nxt = c_ST_EOP;
                        w_se0_nxt   = 1'b1;
                        w_eop_nxt   = 2'd0;
                        w_err_nxt   = ~r_cur_last;
                    end else begin
                        if (r_nbits == 4'd8) begin
                            w_cur_last_nxt = r_buf_last;
                            w_buf_full_nxt = 1'b0;
                            w_nbits_nxt    = 4'd1;
                        end else begin
                            w_nbits_nxt = r_nbits + 4'd1;
                        end
                        w_shift_nxt = {1'b0, w_src[7:1]};
                        if (w_src[0]) begin
                            w_ones_nxt = r_ones + 3'd1;
                        end else begin
                            w_line_nxt = ~r_line;
                            w_ones_nxt = 3'd0;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            c_ST_EOP: begin
                if (w_tick) begin
                    w_cnt_nxt = '0;
                    if (r_eop == 2'd1) begin
                        w_se0_nxt  = 1'b0;
                        w_line_nxt = 1'b1;
                        w_eop_nxt  = 2'd2;
                    end else if (r_eop == 2'd2) begin
                        w_done_nxt   = 1'b1;
                        w_active_nxt = 1'b0;
                        w_state_nxt  = c_ST_IDLE;
                        w_ones_nxt   = 3'd0;
                        w_eop_nxt    = 2'd0;
                    end else begin
                        w_eop_nxt = r_eop + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_buf_data <= 8'd0;
            r_buf_last <= 1'b0;
            r_buf_full <= 1'b0;
            r_shift    <= 8'd0;
            r_cur_last <= 1'b0;
            r_nbits    <= 4'd0;
            r_cnt      <= '0;
            r_line     <= 1'b1;
            r_se0      <= 1'b0;
            r_ones     <= 3'd0;
            r_eop      <= 2'd0;
            r_start    <= 1'b0;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf_data <= w_buf_data_nxt;
            r_buf_last <= w_buf_last_nxt;
            r_buf_full <= w_buf_full_nxt;
            r_shift    <= w_shift_nxt;
            r_cur_last <= w_cur_last_nxt;
            r_nbits    <= w_nbits_nxt;
            r_cnt      <= w_cnt_nxt;
            r_line     <= w_line_nxt;
            r_se0      <= w_se0_nxt;
            r_ones     <= w_ones_nxt;
            r_eop      <= w_eop_nxt;
            r_start    <= w_start_nxt;
            r_active   <= w_active_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_ready    <= ~w_buf_full_nxt;
        end
    end

    assign tx_ready   = r_ready;
    assign dplus_out  = r_se0 ? 1'b0 : r_line;
    assign dminus_out = r_se0 ? 1'b0 : ~r_line;
    assign tx_active  = r_active;
    assign tx_done    = r_done;
    assign tx_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_encoder
// Purpose  : Scoreboard bench for usb_tx_encoder; expected line symbols are
//            queued per packet and checked cycle by cycle by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_encoder;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready, dplus_out, dminus_out, tx_active, tx_done, tx_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_busy = 1'b0;

    typedef struct {
        int kind;   // 0 = first bit cycle, 1 = bit period symbol, 2 = done pulse
        int val;
    } exp_item_t;

    exp_item_t exp_q[$];

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .dplus_out  (dplus_out),
        .dminus_out (dminus_out),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic byte line_sym(input logic dp, input logic dm);
        if (dp === 1'b1 && dm === 1'b0) return "J";
        if (dp === 1'b0 && dm === 1'b1) return "K";
        if (dp === 1'b0 && dm === 1'b0) return "0";
        return "X";
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_pkt(input int start, input string s);
        exp_item_t it;
        it.kind = 0; it.val = start; exp_q.push_back(it);
        for (int i = 0; i < s.len(); i++) begin
            it.kind = 1; it.val = int'(s[i]); exp_q.push_back(it);
        end
        it.kind = 2; it.val = 0; exp_q.push_back(it);
    endtask

    task automatic put(input logic [7:0] d, input logic l, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        tx_valid = 1'b1; tx_data = d; tx_last = l;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_cmp++; n_bad++;
            $display("FAIL put_timeout: tx_ready never rose for byte %0h", d);
        end
        acc = cyc + 1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        check("ready_low_after_accept", {31'd0, tx_ready}, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d items left, got none expected 0", exp_q.size());
        end
        repeat (10) @(negedge clk);
    endtask

    // Monitor: consumes expected items and compares against the live outputs.
    initial begin : monitor
        exp_item_t it;
        int        n;
        int        per;
        bit        ok;
        byte       e, es, got;
        bit        e_err;
        per = 0;
        forever begin
            while (exp_q.size() == 0) @(negedge clk);
            mon_busy = 1'b1;
            it = exp_q.pop_front();
            case (it.kind)
                0: begin
                    n = 0;
                    while (!tx_active && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                    check("first_bit_cycle", cyc, it.val);
                end
                1: begin
                    e     = byte'(it.val);
                    e_err = (e == "E");
                    es    = e_err ? "0" : e;
                    got   = line_sym(dplus_out, dminus_out);
                    ok    = 1'b1;
                    for (int k = 0; k < CPB; k++) begin
                        if (line_sym(dplus_out, dminus_out) != es) ok = 1'b0;
                        if (tx_err !== ((k == 0) && e_err)) ok = 1'b0;
                        if (tx_done !== 1'b0 || tx_active !== 1'b1) ok = 1'b0;
                        @(negedge clk);
                    end
                    n_cmp++;
                    if (!ok) begin
                        n_bad++;
                        $display("FAIL bit_period %0d: got line %c (held/flags wrong) expected %c err=%0b for %0d cycles",
                                 per, got, es, e_err, CPB);
                    end
                    per++;
                end
                default: begin
                    ok = (tx_done === 1'b1) && (tx_active === 1'b0) &&
                         (line_sym(dplus_out, dminus_out) == "J");
                    @(negedge clk);
                    ok = ok && (tx_done === 1'b0);
                    n_cmp++;
                    if (!ok) begin
                        n_bad++;
                        $display("FAIL done_pulse: got done=%0b active=%0b expected one-cycle done with active=0",
                                 tx_done, tx_active);
                    end
                end
            endcase
            mon_busy = 1'b0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        string pre, t1, t2, t3, t4;
        int    acc, dummy, target;
        bit    ok;

`ifdef USB_TX_SYNC_EN
        pre = "KJKJKJKK";
        t1  = "JKJKJKJK";
        t2  = "KKKKKJJJJ";
        t3  = "JKJKJKJJJKKJKKJJKJJJJJKJ";
        t4  = "KJJKKJJK";
`else
        pre = "";
        t1  = "KJKJKJKJ";
        t2  = "JJJJJJKKK";
        t3  = "KJKJKJKKKJJKJJKKJKKKKKJK";
        t4  = "JKKJJKKJ";
`endif

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dplus", {31'd0, dplus_out}, 32'd1);
        check("reset_dminus", {31'd0, dminus_out}, 32'd0);
        check("reset_ready", {31'd0, tx_ready}, 32'd0);
        check("reset_flags", {29'd0, tx_active, tx_done, tx_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, tx_ready}, 32'd1);

        // Single 0x00 byte
        put(8'h00, 1'b1, acc);
        push_pkt(acc + 2, {pre, t1, "00J"});
        drain();

        // 0xFF forces a stuff bit
        put(8'hFF, 1'b1, acc);
        push_pkt(acc + 2, {pre, t2, "00J"});
        drain();

        // Three bytes back to back
        put(8'h80, 1'b0, acc);
        push_pkt(acc + 2, {pre, t3, "00J"});
        put(8'hA5, 1'b0, dummy);
        put(8'h3C, 1'b1, dummy);
        drain();

        // Underrun after a non-last byte
        put(8'h55, 1'b0, acc);
        push_pkt(acc + 2, {pre, t4, "E0J"});
        drain();

        // Reset during bit 3 of a byte
        put(8'h00, 1'b1, acc);
        target = acc + 2 + 3 * CPB + 2;
        while (cyc < target) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_line_j", {24'd0, line_sym(dplus_out, dminus_out)}, {24'd0, 8'h4A});
        check("midrst_active", {31'd0, tx_active}, 32'd0);
        check("midrst_ready_in_rst", {31'd0, tx_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", {31'd0, tx_ready}, 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if (tx_done !== 1'b0 || tx_err !== 1'b0 || tx_active !== 1'b0 ||
                line_sym(dplus_out, dminus_out) != "J") ok = 1'b0;
            @(negedge clk);
        end
        check("midrst_quiet", {31'd0, ok}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
